// File: rtl/bitwise_reduce_acc.sv
// bitwise_reduce_acc
//   Streaming bitwise-reduction engine. Takes a burst of `len` words from a
//   valid/ready source, folds them together with OR, AND, XOR or NOR, and
//   presents the per-bit result plus a single reduced bit until the consumer
//   takes it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a burst (sampled only in IDLE)
//   mode       00 OR, 01 AND, 10 XOR, 11 NOR (sampled with start)
//   len        burst length in words (sampled with start); 0 gives identity result
//   in_valid   source has in_data
//   in_ready   engine accepts in_data this cycle
//   in_data    input word
//   out_valid  result is held on acc_bits/out_bit
//   out_ready  consumer takes the result
//   acc_bits   bitwise-accumulated vector
//   out_bit    reduction of acc_bits under the latched mode
//   busy       engine is not idle
module bitwise_reduce_acc #(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [COUNT_W-1:0] len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   acc_bits,
  output logic               out_bit,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_t;

  state_t             r_state;
  state_t             w_state_next;
  op_t                r_mode;
  logic [COUNT_W-1:0] r_len;
  logic [COUNT_W-1:0] r_count;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   w_acc_next;
  logic               w_beat;
  logic               w_last;
  logic               w_take;

  assign w_beat = in_valid && (r_state == ACCUM);
  // count stops at len-1; the beat that lands there is the final one
  assign w_last = (r_count == r_len - COUNT_W'(1));
  assign w_take = start && (r_state == IDLE);

  // NOR is accumulated as OR; the inversion only applies to the reduced bit
  always_comb begin
    w_acc_next = r_acc | in_data;
    unique case (r_mode)
      OP_AND:  w_acc_next = r_acc & in_data;
      OP_XOR:  w_acc_next = r_acc ^ in_data;
      default: w_acc_next = r_acc | in_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = (len != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        if (w_beat && w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= OP_OR;
      r_len   <= '0;
      r_count <= '0;
      r_acc   <= '0;
    end else if (w_take) begin
      r_mode  <= op_t'(mode);
      r_len   <= len;
      r_count <= '0;
      r_acc   <= (op_t'(mode) == OP_AND) ? '1 : '0;
    end else if (w_beat) begin
      r_acc   <= w_acc_next;
      r_count <= r_count + COUNT_W'(1);
    end
  end

  always_comb begin
    out_bit = |r_acc;
    unique case (r_mode)
      OP_AND:  out_bit = &r_acc;
      OP_XOR:  out_bit = ^r_acc;
      OP_NOR:  out_bit = ~|r_acc;
      default: out_bit = |r_acc;
    endcase
  end

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign acc_bits  = r_acc;

endmodule

// File: tb/tb_bitwise_reduce_acc.sv
module tb_bitwise_reduce_acc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;
  logic [3:0] len;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] acc_bits;
  logic       out_bit;
  logic       busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [4:0] words [16];
  logic [5:0] exp_q [$];

  bitwise_reduce_acc #(.WIDTH(5), .COUNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_bits  (acc_bits),
    .out_bit   (out_bit),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {acc, reduced bit} after folding the first n entries of words[] under mode m
  function automatic logic [5:0] model(input logic [1:0] m, input int unsigned n);
    logic [4:0] a;
    logic       b;
    a = (m == 2'b01) ? 5'b11111 : 5'b00000;
    for (int unsigned i = 0; i < n; i++) begin
      case (m)
        2'b01:   a = a & words[i];
        2'b10:   a = a ^ words[i];
        default: a = a | words[i];
      endcase
    end
    case (m)
      2'b00:   b = |a;
      2'b01:   b = &a;
      2'b10:   b = ^a;
      default: b = ~|a;
    endcase
    return {a, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input logic [1:0] m, input int unsigned l,
                           input bit gaps, input int unsigned hold);
    logic [5:0] e;
    logic [5:0] part;
    exp_q.push_back(model(m, l));
    start = 1'b1; mode = m; len = 4'(l);
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int unsigned i = 0; i < l; i++) begin
      if (gaps && (i % 2 == 1)) begin
        in_valid = 1'b0; in_data = 5'h15;
        tick();
        part = model(m, i);
        chk("gap_acc", acc_bits, part[5:1]);
        chk("gap_ready", in_ready, 1);
      end
      in_valid = 1'b1; in_data = words[i];
      chk("in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    chk("lat_out_valid", out_valid, 1);
    chk("lat_in_ready", in_ready, 0);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    for (int unsigned h = 0; h < hold; h++) begin
      out_ready = 1'b0; in_valid = 1'b1; in_data = 5'h0a;
      chk("hold_valid", out_valid, 1);
      chk("hold_acc", acc_bits, exp_q[0][5:1]);
      chk("hold_bit", out_bit, exp_q[0][0]);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) tick();
    chk("out_valid_timeout", out_valid, 1);
    out_ready = 1'b1;
    start = 1'b1;  // must be ignored during the handoff cycle
    e = exp_q.pop_front();
    chk("res_acc", acc_bits, e[5:1]);
    chk("res_bit", out_bit, e[0]);
    tick();
    out_ready = 1'b0; start = 1'b0;
    chk("post_out_valid", out_valid, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'b00; len = 4'd0;
    in_valid = 1'b0; in_data = 5'd0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_acc", acc_bits, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_bit", out_bit, 0);
    rst_n = 1'b1;
    tick();

    // OR len=1
    words[0] = 5'b00001; run_burst(2'b00, 1, 1'b0, 0);
    words[0] = 5'b00000; run_burst(2'b00, 1, 1'b0, 0);
    // AND len=3
    words[0] = 5'b11111; words[1] = 5'b11110; words[2] = 5'b11111;
    run_burst(2'b01, 3, 1'b0, 1);
    words[1] = 5'b11111; run_burst(2'b01, 3, 1'b0, 0);
    // XOR len=2, NOR len=1
    words[0] = 5'b10101; words[1] = 5'b00101; run_burst(2'b10, 2, 1'b0, 0);
    words[0] = 5'b00000; run_burst(2'b11, 1, 1'b0, 0);
    // gaps mid-burst, consumer stalls 5 cycles
    words[0] = 5'b10001; words[1] = 5'b01100; words[2] = 5'b00110; words[3] = 5'b11011;
    run_burst(2'b10, 4, 1'b1, 5);
    run_burst(2'b00, 4, 1'b1, 5);
    // len=0 identity results
    run_burst(2'b00, 0, 1'b0, 0);
    run_burst(2'b01, 0, 1'b0, 2);
    // maximum length, random data, each mode
    for (int mm = 0; mm < 4; mm++) begin
      for (int i = 0; i < 16; i++) words[i] = 5'($urandom);
      run_burst(2'(mm), 15, (mm % 2 == 1), 1);
    end

    // reset after 2 of 4 beats aborts the burst
    start = 1'b1; mode = 2'b00; len = 4'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 5'b10100; tick();
    in_data = 5'b00011; tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_acc", acc_bits, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_out_bit", out_bit, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_valid", out_valid, 0);
      chk("abort_idle", busy, 0);
    end

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
